dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_3000, first byte address outside data memory.
REQ-002 Parameter CNT_W, default 16, width of per-master grant counters.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mN_valid  input  1  request from master N (N=0,1).
REQ-006 mN_ready  output  1  request accepted this cycle.
REQ-007 mN_we  input  1  1=store, 0=load.
REQ-008 mN_addr  input  32  byte address.
REQ-009 mN_wdata  input  32  store data.
REQ-010 mN_pc  input  32  PC of originating instruction.
REQ-011 mN_rvalid  output  1  response pulse, one cycle after acceptance.
REQ-012 mN_rdata  output  32  load data; valid while mN_rvalid=1.
REQ-013 mN_err  output  1  response is an error; valid while mN_rvalid=1.
REQ-014 dm_addr, dm_wd, dm_pc  output  32 each  address, write data, PC to data memory.
REQ-015 dm_we  output  1  memory write enable.
REQ-016 dm_req  output  1  write inhibit; 1 blocks memory write.
REQ-017 dm_data  input  32  combinational read data from memory.
REQ-018 mN_grants  output  CNT_W  accepted-request count of master N.

Function
REQ-019 At most one master SHALL be granted per cycle; mN_ready SHALL be combinational from mN_valid, reset and the priority pointer.
REQ-020 Only m0 valid -> grant m0; only m1 valid -> grant m1; both valid -> grant the master not granted most recently.
REQ-021 Priority pointer SHALL update to the granted master on every grant and hold otherwise.
REQ-022 Granted request SHALL drive dm_addr/dm_wd/dm_pc from that master in the same cycle; no grant -> dm_addr/dm_wd/dm_pc = 0.
REQ-023 Request is erroneous if addr[1:0]!=0 or addr>=ADDR_LIMIT.
REQ-024 Granted non-erroneous store: dm_we=1, dm_req=0; all other cycles: dm_we=0, dm_req=1.
REQ-025 Erroneous requests SHALL still be granted and consume the slot, with no memory write.
REQ-026 On acceptance, the arbiter SHALL register dm_data (load) or 0 (store or error) into mN_rdata, and the error flag into mN_err; mN_rvalid=1 exactly next cycle, for one cycle.
REQ-027 Erroneous load SHALL return mN_rdata=0, mN_err=1.
REQ-028 Back-to-back acceptances by one master SHALL yield back-to-back rvalid pulses, in order.
REQ-029 mN_rdata/mN_err SHALL hold the last response value until the next response.
REQ-030 mN_grants SHALL increment on each acceptance and saturate at all-ones.
REQ-031 The master SHALL hold valid and payload until ready; the arbiter does not check this.

Reset
REQ-032 reset low SHALL immediately force mN_ready=0, dm_we=0, dm_req=1.
REQ-033 reset low SHALL asynchronously clear mN_rvalid, mN_rdata, mN_err and mN_grants to 0, and set the pointer so m0 wins the first conflict.
REQ-034 A response in flight at reset assertion SHALL be dropped; no rvalid after reset release without a new acceptance.

Structure
REQ-035 Shared package dm_arb_pkg SHALL hold ADDR_LIMIT default, CNT_W default, and the master-id enumeration (M0, M1).
REQ-036 Two-way round-robin grant logic with its pointer SHALL be sub-module rr_arb2.

Verification
REQ-037 After reset release, m0 and m1 both valid -> m0_ready=1 in cycle 1, m1_ready=1 in cycle 2; pattern alternates while both stay valid.
REQ-038 m0 store addr 0x10 wdata 0xDEADBEEF, then m1 load addr 0x10 -> dm_we=1 in the store cycle; m1_rvalid=1 with m1_rdata=0xDEADBEEF, m1_err=0.
REQ-039 m1 store addr 0x3000, then m0 store addr 0x0002 -> dm_we=0 and dm_req=1 throughout; both rvalid pulses carry err=1; memory unchanged.
REQ-040 Force m0_grants to 0xFFFE, issue 3 m0 accepts -> counter reads 0xFFFF and stays there.
REQ-041 Assert reset in the cycle after an m0 load accept -> m0_rvalid=0 immediately and stays 0 after release; m0_grants=0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared defaults and master identifiers for the data-memory arbiter.
package dm_arb_pkg;
   localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_3000;
   localparam int          CNT_W_DEF      = 16;
   typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer remembers the last granted master.
module rr_arb2
   import dm_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   master_e last_q, last_d;
   always_comb begin
      gnt[0] = reset & req[0] & (~req[1] | (last_q == M1));
      gnt[1] = reset & req[1] & (~req[0] | (last_q == M0));
      last_d = gnt[1] ? M1 : gnt[0] ? M0 : last_q;
   end
   // M1 as "last winner" lets m0 take the first conflict after reset
   always_ff @(posedge clk or negedge reset)
      if (!reset) last_q <= M1;
      else        last_q <= last_d;
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between two masters, flags bad
// addresses, and returns a registered one-cycle response per acceptance.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
   parameter int          CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_valid,
   output logic             m0_ready,
   input  logic             m0_we,
   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   input  logic [31:0]      m0_pc,
   output logic             m0_rvalid,
   output logic [31:0]      m0_rdata,
   output logic             m0_err,
   output logic [CNT_W-1:0] m0_grants,
   input  logic             m1_valid,
   output logic             m1_ready,
   input  logic             m1_we,
   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   input  logic [31:0]      m1_pc,
   output logic             m1_rvalid,
   output logic [31:0]      m1_rdata,
   output logic             m1_err,
   output logic [CNT_W-1:0] m1_grants,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_wd,
   output logic [31:0]      dm_pc,
   output logic             dm_we,
   output logic             dm_req,
   input  logic [31:0]      dm_data
);
   logic [1:0]       gnt;
   logic             granted, req_we, req_err;
   logic [31:0]      resp_data;
   logic [1:0]       rvalid_q, rvalid_d, err_q, err_d;
   logic [31:0]      rdata_q [2];
   logic [31:0]      rdata_d [2];
   logic [CNT_W-1:0] grants_q [2];
   logic [CNT_W-1:0] grants_d [2];

   rr_arb2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   ({m1_valid, m0_valid}),
      .gnt   (gnt)
   );

   // gnt already folds in reset, so everything below is quiet during reset
   always_comb begin
      granted   = |gnt;
      dm_addr   = gnt[1] ? m1_addr  : gnt[0] ? m0_addr  : '0;
      dm_wd     = gnt[1] ? m1_wdata : gnt[0] ? m0_wdata : '0;
      dm_pc     = gnt[1] ? m1_pc    : gnt[0] ? m0_pc    : '0;
      req_we    = gnt[1] ? m1_we    : gnt[0] & m0_we;
      req_err   = granted & ((dm_addr[1:0] != 2'b00) | (dm_addr >= ADDR_LIMIT));
      dm_we     = granted & req_we & ~req_err;
      dm_req    = ~dm_we;
      resp_data = (req_we | req_err) ? '0 : dm_data;
   end

   always_comb begin
      rvalid_d = gnt;
      err_d    = err_q;
      for (int i = 0; i < 2; i++) begin
         err_d[i]    = gnt[i] ? req_err : err_q[i];
         rdata_d[i]  = gnt[i] ? resp_data : rdata_q[i];
         grants_d[i] = (gnt[i] & ~&grants_q[i]) ? grants_q[i] + 1'b1 : grants_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rvalid_q <= '0;
         err_q    <= '0;
         for (int i = 0; i < 2; i++) begin
            rdata_q[i]  <= '0;
            grants_q[i] <= '0;
         end
      end else begin
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         for (int i = 0; i < 2; i++) begin
            rdata_q[i]  <= rdata_d[i];
            grants_q[i] <= grants_d[i];
         end
      end

   assign m0_ready  = gnt[0];
   assign m1_ready  = gnt[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata_q[0];
   assign m1_rdata  = rdata_q[1];
   assign m0_grants = grants_q[0];
   assign m1_grants = grants_q[1];
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a
// transaction-level model with its own copy of memory.
module tb_dm_arbiter;
   localparam logic [31:0] LIMIT = 32'h0000_3000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic mem_init = 1'b1;
   logic v [2];
   logic we [2];
   logic [31:0] a [2];
   logic [31:0] wd [2];
   logic [31:0] pc [2];
   logic m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_wd, dm_pc, dm_data;
   logic [15:0] m0_grants, m1_grants;
   logic dm_we, dm_req;
   logic rdy [2];
   logic rv [2];
   logic er [2];
   logic [31:0] rd [2];
   logic [15:0] gr [2];
   logic [31:0] mem [4096];
   logic [31:0] ref_mem [4096];
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dm_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_valid(v[0]), .m0_ready(m0_ready), .m0_we(we[0]), .m0_addr(a[0]),
      .m0_wdata(wd[0]), .m0_pc(pc[0]), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m0_err(m0_err), .m0_grants(m0_grants),
      .m1_valid(v[1]), .m1_ready(m1_ready), .m1_we(we[1]), .m1_addr(a[1]),
      .m1_wdata(wd[1]), .m1_pc(pc[1]), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .m1_err(m1_err), .m1_grants(m1_grants),
      .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_we(dm_we),
      .dm_req(dm_req), .dm_data(dm_data)
   );

   assign rdy[0] = m0_ready;  assign rdy[1] = m1_ready;
   assign rv[0]  = m0_rvalid; assign rv[1]  = m1_rvalid;
   assign er[0]  = m0_err;    assign er[1]  = m1_err;
   assign rd[0]  = m0_rdata;  assign rd[1]  = m1_rdata;
   assign gr[0]  = m0_grants; assign gr[1]  = m1_grants;

   function automatic logic [31:0] seed_word(int i);
      return 32'(i) * 32'h0101_0101 ^ 32'hA5A5_5A5A;
   endfunction

   // the memory behind the arbiter; ref_mem is the model's independent copy
   always @(posedge clk)
      if (mem_init) for (int i = 0; i < 4096; i++) mem[i] <= seed_word(i);
      else if (dm_we) mem[dm_addr[13:2]] <= dm_wd;
   assign dm_data = mem[dm_addr[13:2]];

   task automatic clear_inputs;
      for (int m = 0; m < 2; m++) begin
         v[m] = 1'b0; we[m] = 1'b0; a[m] = '0; wd[m] = '0; pc[m] = '0;
      end
   endtask

   task automatic do_reset;
      reset = 1'b0;
      clear_inputs();
      mem_init = 1'b1;
      repeat (2) @(posedge clk);
      mem_init = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      v[0] = 1'b1; v[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b1; a[0] = 32'h10; a[1] = 32'h20;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m0_ready !== 1'b0) begin fails++; $display("FAIL rst_m0_ready: got %b exp 0", m0_ready); end
      checks++; if (m1_ready !== 1'b0) begin fails++; $display("FAIL rst_m1_ready: got %b exp 0", m1_ready); end
      checks++; if (dm_we !== 1'b0) begin fails++; $display("FAIL rst_dm_we: got %b exp 0", dm_we); end
      checks++; if (dm_req !== 1'b1) begin fails++; $display("FAIL rst_dm_req: got %b exp 1", dm_req); end
      checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin fails++; $display("FAIL rst_flags: got %b exp 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
      checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h exp 0", {m0_rdata, m1_rdata}); end
      checks++; if ({m0_grants, m1_grants} !== 32'h0) begin fails++; $display("FAIL rst_grants: got %h exp 0", {m0_grants, m1_grants}); end
      do_reset();
   endtask

   task automatic test_alternate;
      do_reset();
      @(negedge clk);
      v[0] = 1'b1; v[1] = 1'b1; a[0] = 32'h40; a[1] = 32'h80;
      for (int i = 0; i < 6; i++) begin
         int k, p;
         k = i % 2;
         p = 1 - k;
         #1;
         checks++; if (rdy[k] !== 1'b1 || rdy[p] !== 1'b0) begin fails++; $display("FAIL alt_ready cycle %0d: got m0=%b m1=%b exp m%0d", i, rdy[0], rdy[1], k); end
         checks++; if (dm_addr !== a[k]) begin fails++; $display("FAIL alt_dm_addr cycle %0d: got %h exp %h", i, dm_addr, a[k]); end
         if (i > 0) begin
            checks++; if (rv[p] !== 1'b1 || rd[p] !== ref_mem[a[p][13:2]]) begin fails++; $display("FAIL alt_resp cycle %0d: got rvalid=%b rdata=%h exp 1 %h", i, rv[p], rd[p], ref_mem[a[p][13:2]]); end
         end
         @(negedge clk);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_store_load;
      v[0] = 1'b1; we[0] = 1'b1; a[0] = 32'h10; wd[0] = 32'hDEAD_BEEF; pc[0] = 32'h100;
      #1;
      checks++; if (m0_ready !== 1'b1 || dm_we !== 1'b1 || dm_req !== 1'b0) begin fails++; $display("FAIL st_accept: got ready=%b we=%b req=%b exp 1 1 0", m0_ready, dm_we, dm_req); end
      checks++; if ({dm_addr, dm_wd, dm_pc} !== {32'h10, 32'hDEAD_BEEF, 32'h100}) begin fails++; $display("FAIL st_bus: got %h %h %h exp 10 deadbeef 100", dm_addr, dm_wd, dm_pc); end
      ref_mem[4] = 32'hDEAD_BEEF;
      @(negedge clk);
      clear_inputs();
      v[1] = 1'b1; a[1] = 32'h10; pc[1] = 32'h200;
      #1;
      checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h0) begin fails++; $display("FAIL st_resp: got %b %b %h exp 1 0 0", m0_rvalid, m0_err, m0_rdata); end
      checks++; if (m1_ready !== 1'b1 || dm_we !== 1'b0 || dm_req !== 1'b1) begin fails++; $display("FAIL ld_accept: got ready=%b we=%b req=%b exp 1 0 1", m1_ready, dm_we, dm_req); end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_resp: got %b %b %h exp 1 0 deadbeef", m1_rvalid, m1_err, m1_rdata); end
      checks++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL st_pulse: got %b exp 0", m0_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_hold: got %b %h exp 0 deadbeef", m1_rvalid, m1_rdata); end
      @(negedge clk);
   endtask

   task automatic test_errors;
      v[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h3000; wd[1] = 32'h1234_5678;
      #1;
      checks++; if (m1_ready !== 1'b1 || dm_we !== 1'b0 || dm_req !== 1'b1) begin fails++; $display("FAIL err_lim: got ready=%b we=%b req=%b exp 1 0 1", m1_ready, dm_we, dm_req); end
      @(negedge clk);
      clear_inputs();
      v[0] = 1'b1; we[0] = 1'b1; a[0] = 32'h2; wd[0] = 32'hCAFE_F00D;
      #1;
      checks++; if (m0_ready !== 1'b1 || dm_we !== 1'b0 || dm_req !== 1'b1) begin fails++; $display("FAIL err_mis: got ready=%b we=%b req=%b exp 1 0 1", m0_ready, dm_we, dm_req); end
      checks++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) begin fails++; $display("FAIL err_lim_resp: got %b %b %h exp 1 1 0", m1_rvalid, m1_err, m1_rdata); end
      @(negedge clk);
      clear_inputs();
      v[0] = 1'b1; a[0] = 32'h3004;
      #1;
      checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin fails++; $display("FAIL err_mis_resp: got %b %b %h exp 1 1 0", m0_rvalid, m0_err, m0_rdata); end
      checks++; if (mem[0] !== ref_mem[0] || mem[12'hC00] !== ref_mem[12'hC00]) begin fails++; $display("FAIL err_mem: got %h %h exp %h %h", mem[0], mem[12'hC00], ref_mem[0], ref_mem[12'hC00]); end
      @(negedge clk);
      a[0] = 32'h2FFC;
      #1;
      checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin fails++; $display("FAIL err_ld_resp: got %b %b %h exp 1 1 0", m0_rvalid, m0_err, m0_rdata); end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (m0_err !== 1'b0 || m0_rdata !== ref_mem[12'hBFF]) begin fails++; $display("FAIL edge_ld_resp: got %b %h exp 0 %h", m0_err, m0_rdata, ref_mem[12'hBFF]); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int last, g;
      logic hold [2];
      logic exp_rv [2];
      logic exp_er [2];
      logic [31:0] exp_rd [2];
      int exp_cnt [2];
      logic e, ewe;
      logic [31:0] ea, ewd, epc;
      do_reset();
      last = 1;
      for (int m = 0; m < 2; m++) begin
         hold[m] = 1'b0; exp_rv[m] = 1'b0; exp_er[m] = 1'b0; exp_rd[m] = '0; exp_cnt[m] = 0;
      end
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) if (!hold[m]) begin
            int s;
            v[m]  = $urandom_range(0, 3) != 0;
            we[m] = $urandom_range(0, 1) == 1;
            wd[m] = $urandom;
            pc[m] = $urandom;
            s = $urandom_range(0, 9);
            a[m] = s == 0 ? (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3)) :
                   s == 1 ? LIMIT + (32'($urandom_range(0, 3)) << 2) :
                   s == 2 ? LIMIT - 32'd4 : 32'($urandom_range(0, 63)) << 2;
         end
         g = (v[0] && v[1]) ? 1 - last : v[0] ? 0 : v[1] ? 1 : -1;
         ea = '0; ewd = '0; epc = '0;
         if (g >= 0) begin ea = a[g]; ewd = wd[g]; epc = pc[g]; end
         e = g >= 0 && (ea[1:0] != 2'b00 || ea >= LIMIT);
         ewe = g >= 0 && we[g] && !e;
         #1;
         checks++; if (rdy[0] !== (g == 0) || rdy[1] !== (g == 1)) begin fails++; $display("FAIL rnd_ready cycle %0d: got %b%b exp grant %0d", n, rdy[1], rdy[0], g); end
         checks++; if ({dm_addr, dm_wd, dm_pc} !== {ea, ewd, epc}) begin fails++; $display("FAIL rnd_bus cycle %0d: got %h %h %h exp %h %h %h", n, dm_addr, dm_wd, dm_pc, ea, ewd, epc); end
         checks++; if (dm_we !== ewe || dm_req !== !ewe) begin fails++; $display("FAIL rnd_we cycle %0d: got we=%b req=%b exp we=%b", n, dm_we, dm_req, ewe); end
         for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== exp_rv[m] || er[m] !== exp_er[m] || rd[m] !== exp_rd[m]) begin fails++; $display("FAIL rnd_resp m%0d cycle %0d: got %b %b %h exp %b %b %h", m, n, rv[m], er[m], rd[m], exp_rv[m], exp_er[m], exp_rd[m]); end
            checks++; if (gr[m] !== 16'(exp_cnt[m])) begin fails++; $display("FAIL rnd_grants m%0d cycle %0d: got %0d exp %0d", m, n, gr[m], exp_cnt[m]); end
         end
         for (int m = 0; m < 2; m++) begin
            exp_rv[m] = g == m;
            if (g == m) begin
               exp_rd[m] = (we[m] || e) ? 32'h0 : ref_mem[ea[13:2]];
               exp_er[m] = e;
               if (exp_cnt[m] < 65535) exp_cnt[m]++;
            end
            hold[m] = v[m] && g != m;
         end
         if (ewe) ref_mem[ea[13:2]] = ewd;
         if (g >= 0) last = g;
      end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_saturate;
      do_reset();
      @(negedge clk);
      v[0] = 1'b1; a[0] = 32'h20;
      repeat (65534) @(negedge clk);
      #1;
      checks++; if (m0_grants !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h exp fffe", m0_grants); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++; if (m0_grants !== 16'hFFFF || m0_ready !== 1'b1) begin fails++; $display("FAIL sat_%0d: got %h ready=%b exp ffff 1", k, m0_grants, m0_ready); end
      end
      checks++; if (m1_grants !== 16'h0) begin fails++; $display("FAIL sat_m1: got %h exp 0", m1_grants); end
      clear_inputs();
   endtask

   task automatic test_reset_inflight;
      do_reset();
      @(negedge clk);
      v[0] = 1'b1; a[0] = 32'h40;
      @(negedge clk);
      clear_inputs();
      v[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h44;
      #1;
      checks++; if (m0_rvalid !== 1'b1) begin fails++; $display("FAIL inf_pre: got %b exp 1", m0_rvalid); end
      #1 reset = 1'b0;
      #1;
      checks++; if (m0_rvalid !== 1'b0 || m0_grants !== 16'h0 || m0_rdata !== 32'h0) begin fails++; $display("FAIL inf_clear: got %b %h %h exp 0 0 0", m0_rvalid, m0_grants, m0_rdata); end
      checks++; if (m1_ready !== 1'b0 || dm_we !== 1'b0 || dm_req !== 1'b1) begin fails++; $display("FAIL inf_gate: got ready=%b we=%b req=%b exp 0 0 1", m1_ready, dm_we, dm_req); end
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (m0_rvalid !== 1'b0 || m0_grants !== 16'h0) begin fails++; $display("FAIL inf_after_%0d: got %b %h exp 0 0", k, m0_rvalid, m0_grants); end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_alternate();
      test_store_load();
      test_errors();
      test_random();
      test_reset_inflight();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
